// File: rtl/bsg_manycore_pkg.sv
// Shared state encoding and sizing helpers for the manycore reset sequencer.
package bsg_manycore_pkg;

  typedef enum logic [2:0] {
    e_rs_hold,
    e_rs_settle,
    e_rs_release,
    e_rs_run,
    e_rs_done,
    e_rs_timeout
  } bsg_manycore_reset_seq_state_e;

  localparam int bsg_manycore_reset_stagger_default_gp = 2;

  // Counter width that stays at least one bit for degenerate ranges.
  function automatic int bsg_safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bsg_manycore_reset_stagger.sv
// Releases a per-domain reset vector as a thermometer code, lowest index first,
// one domain every stagger_p cycles after start (all together when stagger_p is 0).
module bsg_manycore_reset_stagger
  import bsg_manycore_pkg::*;
#(
  parameter int num_domains_p = 4,
  parameter int stagger_p     = bsg_manycore_reset_stagger_default_gp
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic                     clear_i,
  output logic [num_domains_p-1:0] reset_o,
  output logic                     last_o
);

  localparam int cnt_w_lp = bsg_safe_clog2(stagger_p + 1);
  localparam int idx_w_lp = bsg_safe_clog2(num_domains_p + 1);
  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'((stagger_p > 0) ? stagger_p - 1 : 0);
  localparam logic [idx_w_lp-1:0] idx_last_lp = idx_w_lp'(num_domains_p - 1);
  localparam bit all_at_once_lp = (stagger_p == 0) || (num_domains_p == 1);

  logic [num_domains_p-1:0] reset_q, reset_d;
  logic [cnt_w_lp-1:0]      cnt_q, cnt_d;
  logic [idx_w_lp-1:0]      idx_q, idx_d;
  logic                     active_q, active_d;

  always_comb begin
    reset_d  = reset_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    active_d = active_q;
    last_o   = 1'b0;
    if (clear_i) begin
      reset_d  = '1;
      cnt_d    = '0;
      idx_d    = '0;
      active_d = 1'b0;
    end else if (start_i) begin
      if (all_at_once_lp) begin
        reset_d = '0;
        last_o  = 1'b1;
      end else begin
        reset_d  = {num_domains_p{1'b1}} << 1;
        idx_d    = idx_w_lp'(1);
        cnt_d    = '0;
        active_d = 1'b1;
      end
    end else if (active_q) begin
      if (cnt_q == cnt_last_lp) begin
        // Shifting the thermometer left releases the next-higher domain.
        reset_d = reset_q << 1;
        idx_d   = idx_q + idx_w_lp'(1);
        cnt_d   = '0;
        if (idx_q == idx_last_lp) begin
          active_d = 1'b0;
          last_o   = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + cnt_w_lp'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      reset_q  <= '1;
      cnt_q    <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
    end else begin
      reset_q  <= reset_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      active_q <= active_d;
    end
  end

  assign reset_o = reset_q;

endmodule

// File: rtl/bsg_manycore_reset_sequencer.sv
// Holds all reset domains until tag programming completes, releases them staggered,
// then counts RUN cycles until finish or timeout; reassert_i replays the sequence.
module bsg_manycore_reset_sequencer
  import bsg_manycore_pkg::*;
#(
  parameter int num_domains_p = 4,
  parameter int reset_depth_p = 3,
  parameter int stagger_p     = bsg_manycore_reset_stagger_default_gp,
  parameter int ctr_width_p   = 32,
  parameter int timeout_p     = 0
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     tag_done_i,
  input  logic                     finish_i,
  input  logic                     reassert_i,
  output logic [num_domains_p-1:0] reset_o,
  output logic                     all_released_o,
  output logic [ctr_width_p-1:0]   cycle_ctr_o,
  output logic                     done_o,
  output logic                     timeout_o
);

  localparam int settle_w_lp = bsg_safe_clog2(reset_depth_p + 1);
  localparam logic [settle_w_lp-1:0] settle_last_lp = settle_w_lp'(reset_depth_p - 1);
  localparam logic [ctr_width_p-1:0] timeout_lp     = ctr_width_p'(timeout_p);

  bsg_manycore_reset_seq_state_e state_q, state_d;
  logic [settle_w_lp-1:0] settle_q, settle_d;
  logic [ctr_width_p-1:0] ctr_q, ctr_d;
  logic all_rel_q, all_rel_d, done_q, done_d, timeout_q, timeout_d;
  logic reassert_hit, tag_drop, settle_done, timeout_hit, stg_clear, stg_last;

  assign reassert_hit = reassert_i && (state_q != e_rs_hold);
  assign tag_drop     = !tag_done_i && ((state_q == e_rs_settle) || (state_q == e_rs_release));
  assign settle_done  = !reassert_hit && tag_done_i && (state_q == e_rs_settle)
                        && (settle_q == settle_last_lp);
  assign timeout_hit  = (timeout_p != 0) && (ctr_q == timeout_lp);
  assign stg_clear    = reassert_hit || tag_drop;

  bsg_manycore_reset_stagger #(
    .num_domains_p(num_domains_p),
    .stagger_p    (stagger_p)
  ) stagger (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .start_i(settle_done),
    .clear_i(stg_clear),
    .reset_o(reset_o),
    .last_o (stg_last)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= e_rs_hold;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (reassert_hit) begin
      state_d = tag_done_i ? e_rs_settle : e_rs_hold;
    end else begin
      case (state_q)
        e_rs_hold:    if (tag_done_i) state_d = e_rs_settle;
        e_rs_settle: begin
          if (!tag_done_i)      state_d = e_rs_hold;
          else if (settle_done) state_d = stg_last ? e_rs_run : e_rs_release;
        end
        e_rs_release: begin
          if (!tag_done_i)   state_d = e_rs_hold;
          else if (stg_last) state_d = e_rs_run;
        end
        // Finish outranks a coincident timeout.
        e_rs_run: begin
          if (finish_i)         state_d = e_rs_done;
          else if (timeout_hit) state_d = e_rs_timeout;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    settle_d  = settle_q;
    ctr_d     = ctr_q;
    all_rel_d = all_rel_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    if (stg_clear) begin
      settle_d  = '0;
      ctr_d     = '0;
      all_rel_d = 1'b0;
      done_d    = 1'b0;
      timeout_d = 1'b0;
    end else begin
      if (stg_last) all_rel_d = 1'b1;
      case (state_q)
        e_rs_hold:   settle_d = '0;
        e_rs_settle: if (!settle_done) settle_d = settle_q + settle_w_lp'(1);
        e_rs_run: begin
          if (finish_i)          done_d    = 1'b1;
          else if (timeout_hit)  timeout_d = 1'b1;
          else if (ctr_q != '1)  ctr_d     = ctr_q + ctr_width_p'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      settle_q  <= '0;
      ctr_q     <= '0;
      all_rel_q <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      settle_q  <= settle_d;
      ctr_q     <= ctr_d;
      all_rel_q <= all_rel_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign all_released_o = all_rel_q;
  assign cycle_ctr_o    = ctr_q;
  assign done_o         = done_q;
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_bsg_manycore_reset_sequencer.sv
// Three sequencer instances on shared stimulus: defaults, stagger 0 with 3 domains, timeout 50.
module tb_bsg_manycore_reset_sequencer;

  logic clk = 1'b0;
  logic rst, tag, fin, re;

  logic [3:0]  rst_a, rst_t;
  logic [2:0]  rst_s;
  logic        rel_a, rel_s, rel_t;
  logic        done_a, done_s, done_t;
  logic        to_a, to_s, to_t;
  logic [31:0] ctr_a, ctr_s, ctr_t;

  always #5 clk = ~clk;

  bsg_manycore_reset_sequencer u_a (
    .clk_i(clk), .reset_i(rst), .tag_done_i(tag), .finish_i(fin), .reassert_i(re),
    .reset_o(rst_a), .all_released_o(rel_a), .cycle_ctr_o(ctr_a), .done_o(done_a), .timeout_o(to_a));

  bsg_manycore_reset_sequencer #(.num_domains_p(3), .stagger_p(0)) u_s (
    .clk_i(clk), .reset_i(rst), .tag_done_i(tag), .finish_i(fin), .reassert_i(re),
    .reset_o(rst_s), .all_released_o(rel_s), .cycle_ctr_o(ctr_s), .done_o(done_s), .timeout_o(to_s));

  bsg_manycore_reset_sequencer #(.timeout_p(50)) u_t (
    .clk_i(clk), .reset_i(rst), .tag_done_i(tag), .finish_i(fin), .reassert_i(re),
    .reset_o(rst_t), .all_released_o(rel_t), .cycle_ctr_o(ctr_t), .done_o(done_t), .timeout_o(to_t));

  typedef struct {
    logic       tag, fin, re;
    logic [3:0] rst_a;
    logic       rel_a;
    int         ctr_a;
    logic       done_a;
    logic [2:0] rst_s;
    logic       rel_s;
    int         ctr_t;
    logic       done_t, to_t;
  } vec_t;

  vec_t  tbl [15];
  vec_t  sb [$];
  int    n_vec = 0;
  int    n_err = 0;
  string phase = "reset";

  function automatic vec_t mk(input logic t, input logic f, input logic r,
                              input logic [3:0] ra, input logic la, input int ca, input logic da,
                              input logic [2:0] rs, input logic ls,
                              input int ct, input logic dt, input logic tt);
    vec_t v;
    v.tag = t; v.fin = f; v.re = r;
    v.rst_a = ra; v.rel_a = la; v.ctr_a = ca; v.done_a = da;
    v.rst_s = rs; v.rel_s = ls;
    v.ctr_t = ct; v.done_t = dt; v.to_t = tt;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%s vec %0d]: got %0h want %0h", nm, phase, n_vec, act, exp);
    end
  endtask

  task automatic check_out();
    vec_t e;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard [%s]: got empty queue want an entry", phase);
      return;
    end
    e = sb.pop_front();
    n_vec++;
    cmp("rst_a",  32'(rst_a),  32'(e.rst_a));
    cmp("rel_a",  32'(rel_a),  32'(e.rel_a));
    cmp("ctr_a",  ctr_a,       32'(e.ctr_a));
    cmp("done_a", 32'(done_a), 32'(e.done_a));
    cmp("to_a",   32'(to_a),   32'd0);
    cmp("rst_s",  32'(rst_s),  32'(e.rst_s));
    cmp("rel_s",  32'(rel_s),  32'(e.rel_s));
    cmp("ctr_t",  ctr_t,       32'(e.ctr_t));
    cmp("done_t", 32'(done_t), 32'(e.done_t));
    cmp("to_t",   32'(to_t),   32'(e.to_t));
  endtask

  // Inputs are driven 1 time unit after an edge; outputs sampled 1 unit after the next edge.
  task automatic apply(input vec_t v);
    tag = v.tag; fin = v.fin; re = v.re;
    sb.push_back(v);
    @(posedge clk); #1;
    check_out();
  endtask

  initial begin
    logic [3:0] rst_tbl [15];
    vec_t v;
    rst_tbl = '{4'hf, 4'hf, 4'hf, 4'he, 4'he, 4'hc, 4'hc, 4'h8, 4'h8,
                4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    // Row k: state after edge Ek, where tag_done_i was first sampled high at E0.
    for (int k = 0; k < 15; k++)
      tbl[k] = mk(1'b1, 1'b0, 1'b0, rst_tbl[k], k >= 9, (k >= 9) ? k - 9 : 0, 1'b0,
                  (k >= 3) ? 3'h0 : 3'h7, k >= 3, (k >= 9) ? k - 9 : 0, 1'b0, 1'b0);

    rst = 1'b1; tag = 1'b0; fin = 1'b0; re = 1'b0;
    #12;
    sb.push_back(mk(0, 0, 0, 4'hf, 0, 0, 0, 3'h7, 0, 0, 0, 0));
    check_out();
    @(posedge clk); #1;
    rst = 1'b0;

    phase = "hold";
    apply(mk(0, 0, 0, 4'hf, 0, 0, 0, 3'h7, 0, 0, 0, 0));
    apply(mk(0, 1, 1, 4'hf, 0, 0, 0, 3'h7, 0, 0, 0, 0));
    apply(mk(0, 0, 0, 4'hf, 0, 0, 0, 3'h7, 0, 0, 0, 0));

    phase = "release";
    for (int k = 0; k < 15; k++) apply(tbl[k]);

    phase = "run";
    for (int k = 15; k < 110; k++)
      apply(mk(1, 0, 0, 4'h0, 1, k - 9, 0, 3'h0, 1, (k - 9 > 50) ? 50 : k - 9, 0, k - 9 > 50));
    apply(mk(1, 1, 0, 4'h0, 1, 100, 1, 3'h0, 1, 50, 0, 1));
    apply(mk(1, 1, 0, 4'h0, 1, 100, 1, 3'h0, 1, 50, 0, 1));
    apply(mk(1, 0, 0, 4'h0, 1, 100, 1, 3'h0, 1, 50, 0, 1));

    phase = "reassert";
    for (int k = 0; k < 15; k++) begin
      v = tbl[k];
      if (k == 0) v.re = 1'b1;
      apply(v);
    end

    phase = "finish_vs_timeout";
    for (int k = 15; k < 60; k++)
      apply(mk(1, 0, 0, 4'h0, 1, k - 9, 0, 3'h0, 1, k - 9, 0, 0));
    apply(mk(1, 1, 0, 4'h0, 1, 50, 1, 3'h0, 1, 50, 1, 0));
    apply(mk(1, 0, 0, 4'h0, 1, 50, 1, 3'h0, 1, 50, 1, 0));

    phase = "tag_drop";
    for (int k = 0; k < 7; k++) begin
      v = tbl[k];
      if (k == 0) v.re = 1'b1;
      apply(v);
    end
    for (int k = 7; k < 10; k++)
      apply(mk(0, 0, 0, 4'hf, 0, 0, 0, 3'h0, 1, 0, 0, 0));
    apply(mk(1, 0, 0, 4'hf, 0, 0, 0, 3'h0, 1, 0, 0, 0));
    apply(mk(1, 0, 0, 4'hf, 0, 0, 0, 3'h0, 1, 0, 0, 0));
    apply(mk(1, 0, 0, 4'hf, 0, 0, 0, 3'h0, 1, 0, 0, 0));
    apply(mk(1, 0, 0, 4'he, 0, 0, 0, 3'h0, 1, 0, 0, 0));

    // Asynchronous reset mid-release must take effect before the next edge.
    phase = "async_reset";
    #2 rst = 1'b1;
    #1;
    sb.push_back(mk(1, 0, 0, 4'hf, 0, 0, 0, 3'h7, 0, 0, 0, 0));
    check_out();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 15; k++) apply(tbl[k]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
